bp_mem_cmd_responder: RTL



---
 rtl/bp_mem_cmd_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bp_mem_cmd_responder.sv
// bp_mem_cmd_responder: single-outstanding cce_mem endpoint backed by a block-wide storage array.
// Define BP_MEM_RESPONDER_CLEAR_EN to zero all storage after every reset before accepting commands.
module bp_mem_cmd_responder #(
    parameter int paddr_width_p = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p = 4,
    parameter int lce_assoc_p = 8,
    parameter int mem_els_p = 1024,
    parameter int mem_latency_p = 4,
    localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p) + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);
    localparam int hdr_w = cce_mem_msg_width_lp - cce_block_width_p;
    localparam int offset_w = $clog2(cce_block_width_p / 8);
    localparam int idx_w = $clog2(mem_els_p);
    localparam int lat_w = $clog2(mem_latency_p + 1);
    localparam int addr_lsb = 4;
    localparam int size_lsb = 4 + paddr_width_p;
    localparam logic [3:0] e_cce_mem_rd = 4'd0;
    localparam logic [3:0] e_cce_mem_wr = 4'd1;
    localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;
    localparam logic [3:0] e_cce_mem_wb = 4'd4;

    typedef enum logic [1:0] {e_ready, e_wait, e_resp, e_clear} state_e;

    state_e                            state_r;
    logic [cce_mem_msg_width_lp-1:0]   cmd_r, resp_r;
    logic                              resp_v_r;
    logic [lat_w-1:0]                  cnt_r;
    logic [cce_block_width_p-1:0]      mem [mem_els_p];
    logic [cce_block_width_p-1:0]      blk, mask, cmd_data, uc_rd_data, uc_wr_blk, rd_data, wr_data;
    logic [15:0]                       sz, off_bits;
    logic [idx_w-1:0]                  idx, wr_idx;
    logic [3:0]                        cmd_type;
    logic                              access, wr_en;
`ifdef BP_MEM_RESPONDER_CLEAR_EN
    logic [idx_w-1:0]                  clr_r;
`endif

    always_comb begin
        cmd_type = cmd_r[3:0];
        cmd_data = cmd_r[hdr_w +: cce_block_width_p];
        idx = cmd_r[addr_lsb + offset_w +: idx_w];
        // Oversized requests collapse to one full block
        sz = (16'(cmd_r[size_lsb +: 3]) > 16'(offset_w)) ? 16'(offset_w) : 16'(cmd_r[size_lsb +: 3]);
        off_bits = ((16'(cmd_r[addr_lsb +: offset_w]) >> sz) << sz) << 3;
        mask = {cce_block_width_p{1'b1}} >> (16'(cce_block_width_p) - (16'd8 << sz));
        blk = mem[idx];
        uc_rd_data = (blk >> off_bits) & mask;
        uc_wr_blk = (blk & ~(mask << off_bits)) | ((cmd_data & mask) << off_bits);
        access = (state_r == e_wait) && (cnt_r == '0);
        rd_data = (cmd_type == e_cce_mem_rd || cmd_type == e_cce_mem_wr) ? blk
                : (cmd_type == e_cce_mem_uc_rd) ? uc_rd_data : '0;
        wr_en = access && (cmd_type == e_cce_mem_wb || cmd_type == e_cce_mem_uc_wr);
        wr_idx = idx;
        wr_data = (cmd_type == e_cce_mem_wb) ? cmd_data : uc_wr_blk;
`ifdef BP_MEM_RESPONDER_CLEAR_EN
        if (state_r == e_clear) begin
            wr_en = 1'b1;
            wr_idx = clr_r;
            wr_data = '0;
        end
`endif
    end

    always_ff @(posedge clk_i)
        if (wr_en) mem[wr_idx] <= wr_data;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
`ifdef BP_MEM_RESPONDER_CLEAR_EN
            state_r <= e_clear;
            clr_r <= '0;
`else
            state_r <= e_ready;
`endif
            cnt_r <= '0;
            cmd_r <= '0;
            resp_r <= '0;
            resp_v_r <= 1'b0;
        end else begin
            case (state_r)
                e_ready: if (mem_cmd_v_i) begin
                    cmd_r <= mem_cmd_i;
                    cnt_r <= lat_w'(mem_latency_p - 1);
                    state_r <= e_wait;
                end
                e_wait: if (cnt_r == '0) begin
                    resp_r <= {rd_data, cmd_r[hdr_w-1:0]};
                    resp_v_r <= 1'b1;
                    state_r <= e_resp;
                end else begin
                    cnt_r <= cnt_r - 1'b1;
                end
                e_resp: if (mem_resp_yumi_i) begin
                    resp_v_r <= 1'b0;
                    state_r <= e_ready;
                end
                default: begin
`ifdef BP_MEM_RESPONDER_CLEAR_EN
                    clr_r <= clr_r + 1'b1;
                    if (clr_r == idx_w'(mem_els_p - 1)) state_r <= e_ready;
`else
                    state_r <= e_ready;
`endif
                end
            endcase
        end
    end

    assign mem_cmd_ready_o = (state_r == e_ready) && !reset_i;
    assign mem_resp_v_o = resp_v_r;
    assign mem_resp_o = resp_r;

    assert property (@(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> mem_resp_v_o);

endmodule
